// File: rtl/datapath_regs_pkg.sv
// Shared constants for the 4-bit CPU register/ALU stage: default width,
// source-select encodings and the register reset value.
package datapath_regs_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    SRC_A    = 2'b00,
    SRC_B    = 2'b01,
    SRC_IN   = 2'b10,
    SRC_ZERO = 2'b11
  } src_sel_e;

  // Every architectural register clears to all zeros.
  localparam logic RESET_BIT = 1'b0;

endpackage

// File: rtl/datapath_regs_reg_en.sv
// WIDTH-bit register with synchronous active-low reset and active-low load.
module reg_en
  import datapath_regs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= {WIDTH{RESET_BIT}};
    end else if (!ld_n) begin
      q <= d;
    end
  end

endmodule

// File: rtl/datapath_regs.sv
// Register/ALU stage: source mux, unsigned add with immediate, registers
// A/B/OUT/PC and the carry flag fed back to the decoder.
module datapath_regs
  import datapath_regs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clkin,
  input  logic             rstnin,
  input  logic             aselin,
  input  logic             bselin,
  input  logic             ld0in,
  input  logic             ld1in,
  input  logic             ld2in,
  input  logic             ld3in,
  input  logic [WIDTH-1:0] immin,
  input  logic [WIDTH-1:0] inpin,
  output logic [WIDTH-1:0] aregout,
  output logic [WIDTH-1:0] bregout,
  output logic [WIDTH-1:0] outpout,
  output logic [WIDTH-1:0] pcout,
  output logic             cout
);

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  src_sel_e         sel;
  logic [WIDTH-1:0] src;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [WIDTH-1:0] pc_q;
  logic             c_q;

  assign sel = src_sel_e'({bselin, aselin});

  always_comb begin
    src = {WIDTH{1'b0}};
    case (sel)
      SRC_A:    src = aregout;
      SRC_B:    src = bregout;
      SRC_IN:   src = inpin;
      SRC_ZERO: src = {WIDTH{1'b0}};
      default:  src = {WIDTH{1'b0}};
    endcase
  end

  assign sum    = {1'b0, src} + {1'b0, immin};
  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

  reg_en #(.WIDTH(WIDTH)) u_reg_a (
    .clk   (clkin),
    .rst_n (rstnin),
    .ld_n  (ld0in),
    .d     (result),
    .q     (aregout)
  );

  reg_en #(.WIDTH(WIDTH)) u_reg_b (
    .clk   (clkin),
    .rst_n (rstnin),
    .ld_n  (ld1in),
    .d     (result),
    .q     (bregout)
  );

  reg_en #(.WIDTH(WIDTH)) u_reg_out (
    .clk   (clkin),
    .rst_n (rstnin),
    .ld_n  (ld2in),
    .d     (result),
    .q     (outpout)
  );

  // PC free-runs unless a jump loads it; the increment wraps naturally.
  always_ff @(posedge clkin) begin
    if (!rstnin) begin
      pc_q <= {WIDTH{RESET_BIT}};
    end else if (!ld3in) begin
      pc_q <= result;
    end else begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  // Carry is captured every cycle so the next instruction can branch on it.
  always_ff @(posedge clkin) begin
    if (!rstnin) begin
      c_q <= RESET_BIT;
    end else begin
      c_q <= carry;
    end
  end

  assign pcout = pc_q;
  assign cout  = c_q;

endmodule

// File: tb/tb_datapath_regs.sv
// Directed bench for datapath_regs: a table of per-cycle vectors with
// hand-computed register state, plus reset-with-X and restart sequences.
module tb_datapath_regs;

  localparam int W = 4;

  typedef struct packed {
    logic         rstn;
    logic [1:0]   sel;   // {bsel, asel}
    logic [3:0]   ld;    // {ld3, ld2, ld1, ld0}, active low
    logic [W-1:0] imm;
    logic [W-1:0] inp;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] o;
    logic [W-1:0] pc;
    logic         c;
  } vec_t;

  localparam int EW = 4 * W + 1;

  logic         clkin;
  logic         rstnin;
  logic         aselin, bselin;
  logic         ld0in, ld1in, ld2in, ld3in;
  logic [W-1:0] immin, inpin;
  logic [W-1:0] aregout, bregout, outpout, pcout;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[$];

  datapath_regs #(.WIDTH(W)) dut (
    .clkin   (clkin),
    .rstnin  (rstnin),
    .aselin  (aselin),
    .bselin  (bselin),
    .ld0in   (ld0in),
    .ld1in   (ld1in),
    .ld2in   (ld2in),
    .ld3in   (ld3in),
    .immin   (immin),
    .inpin   (inpin),
    .aregout (aregout),
    .bregout (bregout),
    .outpout (outpout),
    .pcout   (pcout),
    .cout    (cout)
  );

  // clock / reset block
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures = failures + 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic drive(input logic rstn, input logic [1:0] sel, input logic [3:0] ld,
                       input logic [W-1:0] imm, input logic [W-1:0] inp);
    @(negedge clkin);
    rstnin = rstn;
    bselin = sel[1];
    aselin = sel[0];
    ld3in  = ld[3];
    ld2in  = ld[2];
    ld1in  = ld[1];
    ld0in  = ld[0];
    immin  = imm;
    inpin  = inp;
  endtask

  task automatic expect_state(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] o, input logic [W-1:0] pc, input logic c);
    exp_q.push_back({a, b, o, pc, c});
  endtask

  task automatic cmp(input string name, input int step, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, req);
    end
  endtask

  // scoreboard: pop one expected state after the edge and compare every output
  task automatic check_state(input int step);
    logic [EW-1:0] e;
    @(posedge clkin);
    #1;
    if (exp_q.size() == 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", step);
    end else begin
      e = exp_q.pop_front();
      cmp("areg", step, aregout, e[EW-1 -: W]);
      cmp("breg", step, bregout, e[EW-1-W -: W]);
      cmp("outp", step, outpout, e[EW-1-2*W -: W]);
      cmp("pc",   step, pcout,   e[W:1]);
      cmp("cout", step, {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, e[0]});
    end
  endtask

  function automatic vec_t mk(input logic rstn, input logic [1:0] sel, input logic [3:0] ld,
                              input logic [W-1:0] imm, input logic [W-1:0] inp,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] o, input logic [W-1:0] pc, input logic c);
    vec_t v;
    v.rstn = rstn; v.sel = sel; v.ld = ld; v.imm = imm; v.inp = inp;
    v.a = a; v.b = b; v.o = o; v.pc = pc; v.c = c;
    return v;
  endfunction

  initial begin
    rstnin = 1'b0;
    {bselin, aselin} = 2'b00;
    {ld3in, ld2in, ld1in, ld0in} = 4'b1111;
    immin = '0;
    inpin = '0;

    //            rstn sel    ld       imm   inp    A     B     OUT   PC    C
    vecs.push_back(mk(0, 2'b00, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0)); // reset (random inputs)
    vecs.push_back(mk(0, 2'b00, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0)); // reset (random inputs)
    vecs.push_back(mk(1, 2'b11, 4'b1110, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 4'h1, 0)); // MOV A,5
    vecs.push_back(mk(1, 2'b11, 4'b1110, 4'hE, 4'h0, 4'hE, 4'h0, 4'h0, 4'h2, 0)); // MOV A,E
    vecs.push_back(mk(1, 2'b00, 4'b1110, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h3, 1)); // ADD A,3 carries
    vecs.push_back(mk(1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 0)); // carry clears
    vecs.push_back(mk(1, 2'b10, 4'b1101, 4'h0, 4'hA, 4'h1, 4'hA, 4'h0, 4'h5, 0)); // IN B
    vecs.push_back(mk(1, 2'b01, 4'b1011, 4'h1, 4'h3, 4'h1, 4'hA, 4'hB, 4'h6, 0)); // OUT B+1
    vecs.push_back(mk(1, 2'b11, 4'b0111, 4'hF, 4'h0, 4'h1, 4'hA, 4'hB, 4'hF, 0)); // JMP F
    vecs.push_back(mk(1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h1, 4'hA, 4'hB, 4'h0, 0)); // PC wraps
    vecs.push_back(mk(1, 2'b11, 4'b0111, 4'h9, 4'h0, 4'h1, 4'hA, 4'hB, 4'h9, 0)); // JMP 9
    vecs.push_back(mk(1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h1, 4'hA, 4'hB, 4'hA, 0)); // PC -> A
    vecs.push_back(mk(1, 2'b11, 4'b0000, 4'h7, 4'h0, 4'h7, 4'h7, 4'h7, 4'h7, 0)); // all loads
    vecs.push_back(mk(0, 2'b11, 4'b0000, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0)); // reset wins
    vecs.push_back(mk(1, 2'b10, 4'b1111, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 1)); // carry, no load
    vecs.push_back(mk(1, 2'b10, 4'b1100, 4'h9, 4'h8, 4'h1, 4'h1, 4'h0, 4'h2, 1)); // A,B = 8+9
    vecs.push_back(mk(1, 2'b00, 4'b1011, 4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h3, 1)); // OUT = 1+F wraps
    vecs.push_back(mk(1, 2'b01, 4'b1111, 4'h2, 4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 0)); // idle, C clears

    for (int i = 0; i < vecs.size(); i++) begin
      if (!vecs[i].rstn && i < 2)
        drive(1'b0, 2'($urandom_range(0, 3)), 4'b0000, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)));
      else
        drive(vecs[i].rstn, vecs[i].sel, vecs[i].ld, vecs[i].imm, vecs[i].inp);
      expect_state(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].pc, vecs[i].c);
      check_state(i);
    end

    // Unknown inputs under reset must not reach state.
    drive(1'b0, 2'bxx, 4'b0000, 4'bxxxx, 4'bxxxx);
    {ld3in, ld2in, ld1in, ld0in} = 4'bxxxx;
    expect_state(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    check_state(100);

    // Release mid-program: restart at PC=0 then count, C from first add.
    drive(1'b1, 2'b11, 4'b1111, 4'h0, 4'h0);
    expect_state(4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
    check_state(101);
    drive(1'b1, 2'b10, 4'b1101, 4'h8, 4'h8);
    expect_state(4'h0, 4'h0, 4'h0, 4'h2, 1'b1);
    check_state(102);

    // Sweep PC through a full wrap with all loads idle.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 2'b11, 4'b1111, 4'h0, 4'h0);
      expect_state(4'h0, 4'h0, 4'h0, 4'(3 + k), 1'b0);
      check_state(200 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
